// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared types for the two-port FPU issue controller.
// fp_alu_op_e keeps the ibex_pkg encoding so the core side needs no translation.
package fpu_ctrl_pkg;

   localparam int NUM_REQ = 2;
   localparam int OP_W    = 2;
   localparam int DATA_W  = 16;
   localparam int CNT_W   = 3;

   typedef enum logic [OP_W-1:0] {
      FP_ALU_ADD  = 2'd0,
      FP_ALU_SUB  = 2'd1,
      FP_ALU_MULT = 2'd2
   } fp_alu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } fpu_ctrl_state_e;

   typedef logic req_id_t;

   function automatic logic [NUM_REQ-1:0] id2oh(req_id_t id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/fpu_issue_ctrl_rr_arb.sv
// Two-way round-robin arbiter; the pointer remembers the last port served
// and only moves when the caller reports an accepted handshake.
module fpu_rr_arb
   import fpu_ctrl_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic               advance_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output req_id_t            id_o
);

   req_id_t last_q, last_d;

   always_comb begin
      id_o = 1'b0;
      case (valid_i)
         2'b01:   id_o = 1'b0;
         2'b10:   id_o = 1'b1;
         2'b11:   id_o = ~last_q;
         default: id_o = 1'b0;
      endcase
      gnt_o  = (valid_i != '0) ? id2oh(id_o) : '0;
      last_d = advance_i ? id_o : last_q;
   end

   // Reset as if port 1 was served last so port 0 wins the first tie.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Shares one combinational 16-bit FPU between two requesters, one op at a time.
// Define FPU_CTRL_PERF_EN to add saturating accepted-op and response-stall counters.
module fpu_issue_ctrl
   import fpu_ctrl_pkg::*;
#(
   parameter int EXEC_CYCLES = 2,
   parameter int PERF_CNT_W  = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NUM_REQ-1:0]    req_valid_i,
   output logic [NUM_REQ-1:0]    req_ready_o,
   input  logic [2*OP_W-1:0]     req_op_i,
   input  logic [2*DATA_W-1:0]   req_a_i,
   input  logic [2*DATA_W-1:0]   req_b_i,
   output logic [NUM_REQ-1:0]    rsp_valid_o,
   input  logic [NUM_REQ-1:0]    rsp_ready_i,
   output logic [DATA_W-1:0]     rsp_result_o,
   output logic [OP_W-1:0]       fpu_operator_o,
   output logic [DATA_W-1:0]     fpu_operand_a_o,
   output logic [DATA_W-1:0]     fpu_operand_b_o,
   input  logic [DATA_W-1:0]     fpu_result_i,
`ifdef FPU_CTRL_PERF_EN
   output logic [PERF_CNT_W-1:0] perf_ops_o,
   output logic [PERF_CNT_W-1:0] perf_stall_o,
`endif
   output logic                  busy_o
);

   if (EXEC_CYCLES < 1 || EXEC_CYCLES > 8) begin : g_bad_exec
      $error("fpu_issue_ctrl: EXEC_CYCLES must be 1..8");
   end
   if (PERF_CNT_W < 1) begin : g_bad_perf
      $error("fpu_issue_ctrl: PERF_CNT_W must be >= 1");
   end

   localparam logic [CNT_W-1:0] CntInit = CNT_W'(EXEC_CYCLES - 1);

   fpu_ctrl_state_e   state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   req_id_t           owner_q, owner_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] res_q, res_d;

   logic [NUM_REQ-1:0] arb_valid;
   logic [NUM_REQ-1:0] gnt;
   req_id_t            gnt_id;
   logic               accept;

   assign arb_valid = (state_q == IDLE) ? req_valid_i : '0;

   fpu_rr_arb u_arb (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .valid_i   (arb_valid),
      .advance_i (accept),
      .gnt_o     (gnt),
      .id_o      (gnt_id)
   );

   // Ready is masked while reset is held so no grant leaks out of reset.
   assign req_ready_o = rst_ni ? gnt : '0;
   assign accept      = |(req_valid_i & req_ready_o);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_d     = owner_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      rsp_valid_o = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               owner_d = gnt_id;
               op_d    = gnt_id ? req_op_i[2*OP_W-1:OP_W] : req_op_i[OP_W-1:0];
               a_d     = gnt_id ? req_a_i[2*DATA_W-1:DATA_W] : req_a_i[DATA_W-1:0];
               b_d     = gnt_id ? req_b_i[2*DATA_W-1:DATA_W] : req_b_i[DATA_W-1:0];
               cnt_d   = CntInit;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == '0) begin
               res_d   = fpu_result_i;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            rsp_valid_o = id2oh(owner_q);
            if (rsp_ready_i[owner_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         owner_q <= 1'b0;
         op_q    <= FP_ALU_ADD;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
      end
   end

   assign fpu_operator_o  = op_q;
   assign fpu_operand_a_o = a_q;
   assign fpu_operand_b_o = b_q;
   assign rsp_result_o    = res_q;
   assign busy_o          = (state_q != IDLE);

`ifdef FPU_CTRL_PERF_EN
   logic [PERF_CNT_W-1:0] ops_q, ops_d;
   logic [PERF_CNT_W-1:0] stall_q, stall_d;
   logic                  stall;

   assign stall = (state_q == RESP) && !rsp_ready_i[owner_q];

   always_comb begin
      ops_d   = ops_q;
      stall_d = stall_q;
      if (accept && ops_q != '1) begin
         ops_d = ops_q + 1'b1;
      end
      if (stall && stall_q != '1) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ops_q   <= '0;
         stall_q <= '0;
      end else begin
         ops_q   <= ops_d;
         stall_q <= stall_d;
      end
   end

   assign perf_ops_o   = ops_q;
   assign perf_stall_o = stall_q;
`endif

endmodule
